// File: rtl/mm_pkg.sv
// mm_pkg: shared state encoding and index helpers for the matrix-multiply sequencer.
// Rev 1.0
`default_nettype none

package mm_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  function automatic int el_w(input int n);
    return $clog2(n * n);
  endfunction

  function automatic int ld_w(input int n);
    return $clog2(2 * n * n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

  // 32-bit arithmetic so r*n+c never truncates before the caller narrows it
  function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                      input int unsigned n);
    return r * n + c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mm_idx_cnt.sv
// mm_idx_cnt: nested i/j/k counter for the MAC schedule with wrap flags.
// Rev 1.0
`default_nettype none

module mm_idx_cnt
  import mm_pkg::*;
#(
  parameter int N  = 3,
  parameter int CW = cnt_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          k_adv_i,
  input  logic          ij_adv_i,
  output logic [CW-1:0] i_o,
  output logic [CW-1:0] j_o,
  output logic [CW-1:0] k_o,
  output logic          k_last_o,
  output logic          j_last_o,
  output logic          i_last_o
);

  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  logic [CW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;

  assign k_last_o = (k_q == C_LAST);
  assign j_last_o = (j_q == C_LAST);
  assign i_last_o = (i_q == C_LAST);

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clr_i) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else begin
      if (k_adv_i) k_d = k_last_o ? '0 : k_q + 1'b1;
      // moving to the next result always restarts the inner product
      if (ij_adv_i) begin
        k_d = '0;
        j_d = j_last_o ? '0 : j_q + 1'b1;
        if (j_last_o) i_d = i_last_o ? '0 : i_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  assign i_o = i_q;
  assign j_o = j_q;
  assign k_o = k_q;

endmodule

`default_nettype wire

// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl: load / MAC / output sequencer for the N x N matrix-multiply datapath.
// Rev 1.0
`default_nettype none

module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int N    = 3,
  parameter int EL_W = el_w(N),
  parameter int LD_W = ld_w(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            reload_b_only,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            load_en,
  output logic [LD_W-1:0] load_sel,
  output logic [EL_W-1:0] a_sel,
  output logic [EL_W-1:0] b_sel,
  output logic            mac_en,
  output logic            mac_clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [EL_W-1:0] out_sel,
  output logic            busy,
  output logic            done
);

  localparam int              CW      = cnt_w(N);
  localparam logic [LD_W-1:0] LD_HALF = LD_W'(N * N);
  localparam logic [LD_W-1:0] LD_LAST = LD_W'(2 * N * N - 1);

  logic [2:0]      state_q, state_d;
  logic [LD_W-1:0] ld_q, ld_d;
  logic            cnt_clr, k_adv, ij_adv;
  logic [CW-1:0]   i_w, j_w, k_w;
  logic            k_last, j_last, i_last;

  mm_idx_cnt #(.N(N), .CW(CW)) u_idx (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (cnt_clr),
    .k_adv_i  (k_adv),
    .ij_adv_i (ij_adv),
    .i_o      (i_w),
    .j_o      (j_w),
    .k_o      (k_w),
    .k_last_o (k_last),
    .j_last_o (j_last),
    .i_last_o (i_last)
  );

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    cnt_clr = 1'b0;
    k_adv   = 1'b0;
    ij_adv  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        ld_d    = reload_b_only ? LD_HALF : '0;
        cnt_clr = 1'b1;
      end
      S_LOAD: if (in_valid) begin
        if (ld_q == LD_LAST) begin
          state_d = S_MAC;
          ld_d    = '0;
        end else begin
          ld_d = ld_q + 1'b1;
        end
      end
      S_MAC: begin
        k_adv = 1'b1;
        if (k_last) state_d = S_WAIT;
      end
      S_WAIT: state_d = S_OUT;
      S_OUT: if (out_ready) begin
        if (i_last && j_last) begin
          state_d = S_FIN;
        end else begin
          ij_adv  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
    end
  end

  // index outputs are forced to zero outside their owning state
  assign in_ready  = (state_q == S_LOAD);
  assign load_en   = in_ready & in_valid;
  assign load_sel  = in_ready ? ld_q : '0;
  assign mac_en    = (state_q == S_MAC);
  assign mac_clr   = mac_en & (k_w == '0);
  assign a_sel     = mac_en ? EL_W'(idx(32'(i_w), 32'(k_w), N)) : '0;
  assign b_sel     = mac_en ? EL_W'(idx(32'(k_w), 32'(j_w), N)) : '0;
  assign out_valid = (state_q == S_OUT);
  assign out_sel   = out_valid ? EL_W'(idx(32'(i_w), 32'(j_w), N)) : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);

endmodule

`default_nettype wire

// File: tb/tb_mm_seq_ctrl.sv
// tb_mm_seq_ctrl: directed scoreboard bench for mm_seq_ctrl at N=2 and N=3.
// Rev 1.0
`default_nettype none

module tb_mm_seq_ctrl;

  logic clk = 1'b0;
  logic reset, start, reload_b_only, in_valid, out_ready, use3;
  logic st2, st3;

  logic       ir2, le2, me2, mc2, ov2, by2, dn2;
  logic [2:0] ls2;
  logic [1:0] as2, bs2, os2;
  logic       ir3, le3, me3, mc3, ov3, by3, dn3;
  logic [4:0] ls3;
  logic [3:0] as3, bs3, os3;

  logic [31:0] o_ls, o_as, o_bs, o_os;
  logic        o_ir, o_le, o_me, o_mc, o_ov, o_by, o_dn;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int q[$];

  always #5 clk = ~clk;

  assign st2 = start & ~use3;
  assign st3 = start & use3;

  mm_seq_ctrl #(.N(2)) dut2 (
    .clk(clk), .reset(reset), .start(st2), .reload_b_only(reload_b_only),
    .in_valid(in_valid), .in_ready(ir2), .load_en(le2), .load_sel(ls2),
    .a_sel(as2), .b_sel(bs2), .mac_en(me2), .mac_clr(mc2),
    .out_valid(ov2), .out_ready(out_ready), .out_sel(os2), .busy(by2), .done(dn2)
  );

  mm_seq_ctrl #(.N(3)) dut3 (
    .clk(clk), .reset(reset), .start(st3), .reload_b_only(reload_b_only),
    .in_valid(in_valid), .in_ready(ir3), .load_en(le3), .load_sel(ls3),
    .a_sel(as3), .b_sel(bs3), .mac_en(me3), .mac_clr(mc3),
    .out_valid(ov3), .out_ready(out_ready), .out_sel(os3), .busy(by3), .done(dn3)
  );

  always_comb begin
    o_ls = use3 ? 32'(ls3) : 32'(ls2);
    o_as = use3 ? 32'(as3) : 32'(as2);
    o_bs = use3 ? 32'(bs3) : 32'(bs2);
    o_os = use3 ? 32'(os3) : 32'(os2);
    o_ir = use3 ? ir3 : ir2;
    o_le = use3 ? le3 : le2;
    o_me = use3 ? me3 : me2;
    o_mc = use3 ? mc3 : mc2;
    o_ov = use3 ? ov3 : ov2;
    o_by = use3 ? by3 : by2;
    o_dn = use3 ? dn3 : dn2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {o_ir, o_le, o_me, o_mc, o_ov, o_by, o_dn}, 0);
    chk({tag, "_idx"}, o_ls | o_as | o_bs | o_os, 0);
  endtask

  // One complete operation with per-cycle checks; must be entered at a negedge with the DUT idle.
  task automatic run_op(input bit n3, input bit rb, input bit gap, input int stall_sel,
                        input int stall_n, input bit poke_start, input bit abort_mac);
    int n, nn, exp_ld, t_first, t_ev, kc, stalled, e, i, j;
    bit seen_done, prev_hold;
    n = n3 ? 3 : 2;
    nn = n * n;
    use3 = n3;
    start = 1'b1; reload_b_only = rb; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("idle_in_ready", o_ir, 0);
    chk("idle_load_en", o_le, 0);
    chk("idle_busy", o_by, 0);
    for (int r = 0; r < nn; r++) q.push_back(r);
    step();
    start = 1'b0; reload_b_only = ~rb;
    exp_ld = rb ? nn : 0;
    t_first = cyc;
    t_ev = cyc;
    for (int c = 0; c < 200 && exp_ld < 2 * nn; c++) begin
      in_valid = gap ? (c % 2 == 0) : 1'b1;
      #1;
      chk("ld_in_ready", o_ir, 1);
      chk("ld_sel", o_ls, exp_ld);
      chk("ld_en", o_le, in_valid);
      chk("ld_mac_en", o_me, 0);
      if (in_valid) begin
        exp_ld++;
        if (exp_ld == 2 * nn) t_ev = cyc;
      end
      step();
    end
    chk("ld_complete", exp_ld, 2 * nn);
    kc = 0; stalled = 0; seen_done = 1'b0; prev_hold = 1'b0;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      e = (q.size() > 0) ? q[0] : 0;
      i = e / n;
      j = e % n;
      out_ready = 1'b1;
      if (o_ov && e == stall_sel && stalled < stall_n) begin
        out_ready = 1'b0;
        stalled++;
      end
      start = poke_start & o_ov;
      in_valid = 1'b1;
      #1;
      if (abort_mac && o_me && kc == 1) begin
        start = 1'b0; in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk_all_zero("abort");
        step();
        reset = 1'b0;
        q.delete();
        return;
      end
      if (prev_hold) chk("hold_out_valid", o_ov, 1);
      chk("cmp_load_en", o_le, 0);
      if (o_dn) begin
        chk("done_busy", o_by, 1);
        chk("done_queue_empty", q.size(), 0);
        chk("done_out_valid", o_ov, 0);
        if (!gap && stall_n == 0)
          chk("done_latency", cyc - t_first, (rb ? nn : 2 * nn) + nn * (n + 2));
        seen_done = 1'b1;
      end else if (o_me) begin
        chk("mac_a_sel", o_as, i * n + kc);
        chk("mac_b_sel", o_bs, kc * n + j);
        chk("mac_clr", o_mc, kc == 0);
        chk("mac_out_valid", o_ov, 0);
        kc++;
      end else if (o_ov) begin
        if (!prev_hold) begin
          chk("out_gap", cyc - t_ev, n + 2);
          chk("mac_beats", kc, n);
        end
        chk("out_sel", o_os, e);
        chk("out_mac_en", o_me, 0);
        if (out_ready) begin
          void'(q.pop_front());
          t_ev = cyc;
          kc = 0;
        end
      end else begin
        chk("wait_mac_beats", kc, n);
        chk("wait_busy", o_by, 1);
      end
      prev_hold = o_ov & ~out_ready;
      step();
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("done_seen", seen_done, 1);
    #1;
    chk("done_one_cycle", o_dn, 0);
    chk("back_to_idle", o_by, 0);
    step();
    #1;
    chk("stays_idle", o_by, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; reload_b_only = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; use3 = 1'b0;
    step(); step();
    #1;
    chk_all_zero("reset2");
    use3 = 1'b1;
    #1;
    chk_all_zero("reset3");
    use3 = 1'b0;
    step();
    reset = 1'b0;
    step();

    run_op(1'b0, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0);  // full load, N=2
    run_op(1'b1, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0);  // full operand schedule, N=3
    run_op(1'b0, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0);  // stalled input stream
    run_op(1'b0, 1'b0, 1'b0,  2, 5, 1'b0, 1'b0);  // backpressure on out_sel=2
    run_op(1'b0, 1'b1, 1'b0, -1, 0, 1'b1, 1'b0);  // B-only reload, start poked in OUT
    run_op(1'b0, 1'b0, 1'b0, -1, 0, 1'b0, 1'b1);  // reset mid-MAC
    run_op(1'b0, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0);  // clean run after abort

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
